// File: rtl/seven_seg_pkg.sv
// Shared segment types, glyph table and polarity helper
// for the multiplexed seven-segment scanner.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0 = 7'b1111110;
  localparam seg_t SEG_1 = 7'b0110000;
  localparam seg_t SEG_2 = 7'b1101101;
  localparam seg_t SEG_3 = 7'b1111001;
  localparam seg_t SEG_4 = 7'b0110011;
  localparam seg_t SEG_5 = 7'b1011011;
  localparam seg_t SEG_6 = 7'b1011111;
  localparam seg_t SEG_7 = 7'b1110000;
  localparam seg_t SEG_8 = 7'b1111111;
  localparam seg_t SEG_9 = 7'b1110011;
  localparam seg_t SEG_A = 7'b1110111;
  localparam seg_t SEG_B = 7'b0011111;
  localparam seg_t SEG_C = 7'b1001110;
  localparam seg_t SEG_D = 7'b0111101;
  localparam seg_t SEG_E = 7'b1001111;
  localparam seg_t SEG_F = 7'b1000111;

  localparam seg_t SEG_BLANK = 7'b0000000;

  function automatic seg_t seg_pol(
    input seg_t s,
    input logic act_low
  );
    return act_low ? ~s : s;
  endfunction

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational nibble to segment decoder, a..g in bit6..bit0.
// Letters A-F are optional; when disabled they decode blank.
module seven_seg_hex_decode
  import seven_seg_pkg::*;
#(
  parameter int HEX_EN = 1
) (
  input  logic [3:0] i_nib,
  output seg_t       o_seg
);

  localparam bit LETTERS = (HEX_EN != 0);

  always_comb begin
    o_seg = SEG_BLANK;
    unique case (i_nib)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = LETTERS ? SEG_A : SEG_BLANK;
      4'hB: o_seg = LETTERS ? SEG_B : SEG_BLANK;
      4'hC: o_seg = LETTERS ? SEG_C : SEG_BLANK;
      4'hD: o_seg = LETTERS ? SEG_D : SEG_BLANK;
      4'hE: o_seg = LETTERS ? SEG_E : SEG_BLANK;
      4'hF: o_seg = LETTERS ? SEG_F : SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit seven-segment driver with double
// buffering, dead-time guard and leading-zero blanking.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 2,
  parameter int HEX_EN         = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic                  enable,
  input  logic                  lz_blank,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   digit_en,
  output logic                  frame_start
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] TICK_DEAD = TW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  localparam logic SEG_LOW = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_LOW = (DIG_ACTIVE_LOW != 0);

  localparam seg_t SEG_OFF = seg_pol(SEG_BLANK, SEG_LOW);
  localparam logic DP_OFF  = SEG_LOW;
  localparam logic [N_DIGITS-1:0] DIG_OFF = {N_DIGITS{DIG_LOW}};

  logic [TW-1:0]         r_tick;
  logic [IW-1:0]         r_idx;
  logic [4*N_DIGITS-1:0] r_pend_data;
  logic [N_DIGITS-1:0]   r_pend_dp;
  logic                  r_pend;
  logic [4*N_DIGITS-1:0] r_disp_data;
  logic [N_DIGITS-1:0]   r_disp_dp;
  seg_t                  r_seg;
  logic                  r_dp;
  logic [N_DIGITS-1:0]   r_dig;
  logic                  r_fs;

  logic                  w_boundary;
  logic                  w_dead;
  logic [3:0]            w_nib;
  logic                  w_dpsel;
  logic                  w_blank;
  logic [N_DIGITS-1:0]   w_lz;
  logic [N_DIGITS-1:0]   w_onehot;
  seg_t                  w_dec;

  assign w_boundary = enable && (r_tick == '0) && (r_idx == '0);
  assign w_dead     = (DEAD_CYCLES > 0) && (r_tick < TICK_DEAD);

  // A digit is a leading zero when it and every digit above it is zero.
  always_comb begin
    logic w_zhi;
    w_zhi = 1'b1;
    w_lz  = '0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      w_zhi   = w_zhi && (r_disp_data[4*i +: 4] == 4'h0);
      w_lz[i] = w_zhi;
    end
  end

  always_comb begin
    w_nib    = '0;
    w_dpsel  = 1'b0;
    w_blank  = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib       = r_disp_data[4*i +: 4];
        w_dpsel     = r_disp_dp[i];
        w_blank     = lz_blank && w_lz[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  seven_seg_hex_decode #(
    .HEX_EN (HEX_EN)
  ) u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick      <= '0;
      r_idx       <= '0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pend      <= 1'b0;
      r_disp_data <= '0;
      r_disp_dp   <= '0;
      r_seg       <= SEG_OFF;
      r_dp        <= DP_OFF;
      r_dig       <= DIG_OFF;
      r_fs        <= 1'b0;
    end else begin
      if (!enable) begin
        r_tick <= '0;
        r_idx  <= '0;
      end else if (r_tick == TICK_LAST) begin
        r_tick <= '0;
        r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_tick <= r_tick + 1'b1;
      end

      // Commit sees the old pending value; a same-cycle load waits.
      if (w_boundary && r_pend) begin
        r_disp_data <= r_pend_data;
        r_disp_dp   <= r_pend_dp;
      end
      if (load) begin
        r_pend_data <= data_in;
        r_pend_dp   <= dp_in;
        r_pend      <= 1'b1;
      end else if (w_boundary) begin
        r_pend <= 1'b0;
      end

      r_fs <= w_boundary;

      if (!enable || w_dead) begin
        r_seg <= SEG_OFF;
        r_dp  <= DP_OFF;
        r_dig <= DIG_OFF;
      end else begin
        r_seg <= seg_pol(w_blank ? SEG_BLANK : w_dec, SEG_LOW);
        r_dp  <= SEG_LOW ? ~w_dpsel : w_dpsel;
        r_dig <= DIG_LOW ? ~w_onehot : w_onehot;
      end
    end
  end

  assign segments    = r_seg;
  assign dp          = r_dp;
  assign digit_en    = r_dig;
  assign frame_start = r_fs;

endmodule
